dispense_scheduler: RTL and testbench

Sequencing controller for the vending machine's 8 product-slot dispense motors. It takes up to 8 concurrent dispense requests, grants one at a time in round-robin order, and drives the select/enable inputs of the downstream 3:8 motor decoder. Each motor gets a fixed-length pulse, and a cooldown follows every pulse. It sits between the purchase/payment logic, which raises requests, and the decoder feeding the motor drivers.

---
 rtl/vend_pkg.sv | 13 +
 rtl/dispense_scheduler_rr_pick8.sv | 22 ++
 rtl/dispense_scheduler.sv | 116 +++++++++++
 tb/tb_dispense_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and sizes for the vending machine dispense path.
package vend_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/dispense_scheduler_rr_pick8.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping mod 8.
module rr_pick8
  import vend_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [SLOT_W-1:0]    ptr,
  output logic                 valid,
  output logic [SLOT_W-1:0]    idx
);

  // Scan offsets from farthest to nearest so the closest set bit to ptr wins.
  always_comb begin
    valid = |req;
    idx   = ptr;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (req[ptr + SLOT_W'(i)]) begin
        idx = ptr + SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Round-robin sequencer for the 8 dispense motors: one fixed-length pulse at a time,
// followed by a forced cooldown; inhibit blocks grants and aborts an active pulse.
module dispense_scheduler
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned COOLDOWN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] req,
  input  logic                 inhibit,
  output logic [SLOT_W-1:0]    dec_sel,
  output logic                 dec_en,
  output logic [NUM_SLOTS-1:0] ack,
  output logic                 busy,
  output logic [SLOT_W-1:0]    last_slot
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > COOLDOWN_CYCLES) ? PULSE_CYCLES
                                                                       : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [SLOT_W-1:0]    ptr, ptr_nxt;
  logic [SLOT_W-1:0]    sel_nxt;
  logic [SLOT_W-1:0]    last_nxt;
  logic                 en_nxt;
  logic                 busy_nxt;
  logic [NUM_SLOTS-1:0] ack_nxt;
  logic                 pick_valid;
  logic [SLOT_W-1:0]    pick_idx;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      dec_sel   <= '0;
      dec_en    <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      last_slot <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      dec_sel   <= sel_nxt;
      dec_en    <= en_nxt;
      ack       <= ack_nxt;
      busy      <= busy_nxt;
      last_slot <= last_nxt;
    end
  end

  // Outputs are computed as next-state values so every port comes straight from a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    sel_nxt   = dec_sel;
    last_nxt  = last_slot;
    en_nxt    = 1'b0;
    ack_nxt   = '0;

    case (state)
      IDLE: begin
        if (pick_valid && !inhibit) begin
          state_nxt = DRIVE;
          sel_nxt   = pick_idx;
          cnt_nxt   = '0;
          en_nxt    = 1'b1;
        end
      end
      DRIVE: begin
        // Inhibit wins over completion, so an abort never produces an ack.
        if (inhibit) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
          ack_nxt   = NUM_SLOTS'(1) << dec_sel;
          last_nxt  = dec_sel;
          ptr_nxt   = dec_sel + SLOT_W'(1);
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          en_nxt    = 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt == CNT_W'(COOLDOWN_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed self-checking bench for dispense_scheduler (PULSE_CYCLES=16, COOLDOWN_CYCLES=4).
module tb_dispense_scheduler;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       inhibit = 1'b0;
  logic [2:0] dec_sel;
  logic       dec_en;
  logic [7:0] ack;
  logic       busy;
  logic [2:0] last_slot;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dispense_scheduler #(
    .PULSE_CYCLES    (16),
    .COOLDOWN_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .inhibit   (inhibit),
    .dec_sel   (dec_sel),
    .dec_en    (dec_en),
    .ack       (ack),
    .busy      (busy),
    .last_slot (last_slot)
  );

  task automatic wait_en(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dec_en === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack !== 8'h00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit bad;
    req = 8'hFF;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({dec_sel, dec_en, ack, busy, last_slot} !== 16'h0)
      $display("FAIL reset_async: outputs=%04h exp 0000", {dec_sel, dec_en, ack, busy, last_slot}); else passes++;
    repeat (3) @(negedge clk);
    checks++; if ({dec_sel, dec_en, ack, busy, last_slot} !== 16'h0)
      $display("FAIL reset_held: outputs=%04h exp 0000", {dec_sel, dec_en, ack, busy, last_slot}); else passes++;
    req = 8'h00;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dec_en !== 1'b0 || busy !== 1'b0 || ack !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL reset_idle: activity seen with req=0 got dec_en=%b busy=%b exp 0", dec_en, busy); else passes++;
  endtask

  task automatic test_single();
    bit ok, extra;
    int n, b;
    req = 8'b0000_0100;
    @(negedge clk);
    checks++; if (dec_en !== 1'b1 || dec_sel !== 3'd2 || busy !== 1'b1)
      $display("FAIL single_grant: dec_en=%b sel=%0d busy=%b exp 1/2/1", dec_en, dec_sel, busy); else passes++;
    n = 1;
    extra = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dec_en !== 1'b1) break;
      if (ack !== 8'h00) extra = 1'b1;
      n++;
    end
    checks++; if (n != 16) $display("FAIL single_pulse_len: got %0d exp 16", n); else passes++;
    checks++; if (ack !== 8'b0000_0100 || last_slot !== 3'd2)
      $display("FAIL single_ack: ack=%02h last=%0d exp 04/2", ack, last_slot); else passes++;
    checks++; if (dec_sel !== 3'd2) $display("FAIL single_sel_hold: got %0d exp 2", dec_sel); else passes++;
    req = 8'h00;
    b = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack !== 8'h00) extra = 1'b1;
      if (busy !== 1'b1) break;
      b++;
    end
    checks++; if (b != 4) $display("FAIL single_cooldown: busy after dec_en fall got %0d exp 4", b); else passes++;
    checks++; if (extra) $display("FAIL single_ack_width: ack outside its one cycle got 1 exp 0"); else passes++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_order [4];
    logic [7:0] exp_ack;
    bit ok;
    exp_order = '{3'd0, 3'd7, 3'd0, 3'd7};
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'b1000_0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_en(1'b1, ok);
      checks++; if (!ok || dec_sel !== exp_order[k])
        $display("FAIL rr_grant%0d: sel=%0d ok=%b exp %0d", k, dec_sel, ok, exp_order[k]); else passes++;
      wait_ack(ok);
      exp_ack = 8'h01 << exp_order[k];
      checks++; if (!ok || ack !== exp_ack)
        $display("FAIL rr_ack%0d: got %02h exp %02h", k, ack, exp_ack); else passes++;
      req[exp_order[k]] = 1'b0;
      if (k < 3) begin
        repeat (2) @(negedge clk);
        req[exp_order[k]] = 1'b1;
      end
    end
    req = 8'h00;
    wait_idle(ok);
  endtask

  task automatic test_abort();
    bit ok, extra;
    int b;
    req = 8'b0000_0100;
    wait_ack(ok);
    req = 8'h00;
    wait_idle(ok);
    req = 8'b0000_1000;
    wait_en(1'b1, ok);
    checks++; if (!ok || dec_sel !== 3'd3) $display("FAIL abort_grant: sel=%0d exp 3", dec_sel); else passes++;
    repeat (4) @(negedge clk);
    inhibit = 1'b1;
    @(negedge clk);
    checks++; if (dec_en !== 1'b0 || ack !== 8'h00 || busy !== 1'b1 || last_slot !== 3'd2)
      $display("FAIL abort_drop: en=%b ack=%02h busy=%b last=%0d exp 0/00/1/2", dec_en, ack, busy, last_slot); else passes++;
    inhibit = 1'b0;
    req = 8'b0000_1001;
    b = 1;
    extra = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack !== 8'h00) extra = 1'b1;
      if (busy !== 1'b1) break;
      b++;
    end
    checks++; if (b != 4 || extra) $display("FAIL abort_cooldown: busy cycles %0d ack=%b exp 4/0", b, extra); else passes++;
    wait_en(1'b1, ok);
    checks++; if (!ok || dec_sel !== 3'd3) $display("FAIL abort_regrant: sel=%0d exp 3", dec_sel); else passes++;
    wait_ack(ok);
    checks++; if (!ok || ack !== 8'h08) $display("FAIL abort_ack3: got %02h exp 08", ack); else passes++;
    req = 8'b0000_0001;
    wait_en(1'b1, ok);
    checks++; if (!ok || dec_sel !== 3'd0) $display("FAIL abort_next: sel=%0d exp 0", dec_sel); else passes++;
    wait_ack(ok);
    req = 8'h00;
    wait_idle(ok);
  endtask

  task automatic test_abort_last();
    bit ok, bad;
    req = 8'b0000_0010;
    wait_en(1'b1, ok);
    bad = !ok || dec_sel !== 3'd1;
    repeat (15) begin
      @(negedge clk);
      if (dec_en !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL last_pulse: en=%b sel=%0d exp 1/1", dec_en, dec_sel); else passes++;
    inhibit = 1'b1;
    @(negedge clk);
    checks++; if (dec_en !== 1'b0 || ack !== 8'h00 || last_slot !== 3'd0)
      $display("FAIL last_inhibit_wins: en=%b ack=%02h last=%0d exp 0/00/0", dec_en, ack, last_slot); else passes++;
    inhibit = 1'b0;
    req = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad || busy !== 1'b0) $display("FAIL last_no_ack: late ack=%b busy=%b exp 0/0", bad, busy); else passes++;
  endtask

  task automatic test_inhibit_idle();
    bit ok, bad;
    inhibit = 1'b1;
    req = 8'b0001_0000;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dec_en !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL inh_idle_block: grant while inhibited got 1 exp 0"); else passes++;
    inhibit = 1'b0;
    @(negedge clk);
    checks++; if (dec_en !== 1'b1 || dec_sel !== 3'd4)
      $display("FAIL inh_idle_release: en=%b sel=%0d exp 1/4", dec_en, dec_sel); else passes++;
    wait_ack(ok);
    checks++; if (!ok || ack !== 8'h10) $display("FAIL inh_idle_ack: got %02h exp 10", ack); else passes++;
    req = 8'h00;
    wait_idle(ok);
  endtask

  task automatic test_async_reset();
    bit ok, bad;
    req = 8'b0100_0000;
    wait_en(1'b1, ok);
    repeat (3) @(negedge clk);
    checks++; if (dec_en !== 1'b1 || dec_sel !== 3'd6)
      $display("FAIL areset_drive: en=%b sel=%0d exp 1/6", dec_en, dec_sel); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dec_en !== 1'b0 || busy !== 1'b0 || dec_sel !== 3'd0 || last_slot !== 3'd0)
      $display("FAIL areset_drop: en=%b busy=%b sel=%0d last=%0d exp 0/0/0/0", dec_en, busy, dec_sel, last_slot); else passes++;
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ack !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL areset_no_ack: ack after reset got 1 exp 0"); else passes++;
    req = 8'b0010_0001;
    wait_en(1'b1, ok);
    checks++; if (!ok || dec_sel !== 3'd0) $display("FAIL areset_ptr: sel=%0d exp 0", dec_sel); else passes++;
    wait_ack(ok);
    checks++; if (!ok || ack !== 8'h01) $display("FAIL areset_ack: got %02h exp 01", ack); else passes++;
    req = 8'h00;
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_abort_last();
    test_inhibit_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
